port_result_collector: RTL and testbench



---
 rtl/port_result_collector_if.sv | 44 ++++
 rtl/port_result_collector.sv | 100 ++++++++++
 tb/tb_port_result_collector.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/port_result_collector_if.sv
// port_result_collector_if: controller command/result and checker event bundle for one test port.
// Adds res_len_min/res_len_max when PORT_RESULT_COLLECTOR_MINMAX_EN is defined.
interface port_result_collector_if #(
    parameter int FRAME_CNT_WIDTH = 48,
    parameter int BYTE_CNT_WIDTH  = 64,
    parameter int ERR_CNT_WIDTH   = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int DRAIN_WIDTH     = 16
);
    logic                       start;
    logic                       stop;
    logic [DRAIN_WIDTH-1:0]     cfg_drain_cycles;
    logic                       ev_valid;
    logic [LEN_WIDTH-1:0]       ev_len;
    logic                       ev_bad;
    logic                       ready;
    logic                       res_valid;
    logic [FRAME_CNT_WIDTH-1:0] res_frames;
    logic [FRAME_CNT_WIDTH-1:0] res_good;
    logic [BYTE_CNT_WIDTH-1:0]  res_bytes;
    logic [ERR_CNT_WIDTH-1:0]   res_errors;
`ifdef PORT_RESULT_COLLECTOR_MINMAX_EN
    logic [LEN_WIDTH-1:0]       res_len_min;
    logic [LEN_WIDTH-1:0]       res_len_max;

    modport master (
        output start, stop, cfg_drain_cycles, ev_valid, ev_len, ev_bad,
        input  ready, res_valid, res_frames, res_good, res_bytes, res_errors, res_len_min, res_len_max
    );
    modport slave (
        input  start, stop, cfg_drain_cycles, ev_valid, ev_len, ev_bad,
        output ready, res_valid, res_frames, res_good, res_bytes, res_errors, res_len_min, res_len_max
    );
`else
    modport master (
        output start, stop, cfg_drain_cycles, ev_valid, ev_len, ev_bad,
        input  ready, res_valid, res_frames, res_good, res_bytes, res_errors
    );
    modport slave (
        input  start, stop, cfg_drain_cycles, ev_valid, ev_len, ev_bad,
        output ready, res_valid, res_frames, res_good, res_bytes, res_errors
    );
`endif
endinterface

// File: rtl/port_result_collector.sv
// port_result_collector: per-port session FSM with saturating frame/byte/error counters and a post-stop drain window.
// Optional min/max frame length tracking under PORT_RESULT_COLLECTOR_MINMAX_EN.
module port_result_collector #(
    parameter int FRAME_CNT_WIDTH = 48,
    parameter int BYTE_CNT_WIDTH  = 64,
    parameter int ERR_CNT_WIDTH   = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int DRAIN_WIDTH     = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    port_result_collector_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]                 state, state_nx;
    logic [DRAIN_WIDTH-1:0]     drain_cnt;
    logic                       ready, res_valid;
    logic [FRAME_CNT_WIDTH-1:0] frames, good;
    logic [BYTE_CNT_WIDTH-1:0]  bytes;
    logic [ERR_CNT_WIDTH-1:0]   errors;
    logic [BYTE_CNT_WIDTH:0]    bytes_sum;
    logic                       launch, halt, count;

    // start only launches from a resting state; in RUNNING a coincident stop takes priority
    assign launch    = bus.start && (state == IDLE || state == DONE);
    assign halt      = bus.stop && state == RUNNING;
    assign count     = bus.ev_valid && (state == RUNNING || state == DRAIN);
    assign bytes_sum = {1'b0, bytes} + (BYTE_CNT_WIDTH+1)'(bus.ev_len);
    assign state_nx  = launch ? RUNNING :
                       halt ? DRAIN :
                       (state == DRAIN && drain_cnt == '0) ? DONE : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            ready     <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            ready     <= state_nx == IDLE || state_nx == DONE;
            res_valid <= state_nx == DONE;
            if (halt)
                drain_cnt <= bus.cfg_drain_cycles;
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DRAIN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames <= '0;
            good   <= '0;
            bytes  <= '0;
            errors <= '0;
        end else if (launch) begin
            frames <= '0;
            good   <= '0;
            bytes  <= '0;
            errors <= '0;
        end else if (count) begin
            frames <= &frames ? frames : frames + FRAME_CNT_WIDTH'(1);
            good   <= (bus.ev_bad || &good) ? good : good + FRAME_CNT_WIDTH'(1);
            errors <= (!bus.ev_bad || &errors) ? errors : errors + ERR_CNT_WIDTH'(1);
            bytes  <= bytes_sum[BYTE_CNT_WIDTH] ? '1 : bytes_sum[BYTE_CNT_WIDTH-1:0];
        end
    end

    assign bus.ready      = ready;
    assign bus.res_valid  = res_valid;
    assign bus.res_frames = frames;
    assign bus.res_good   = good;
    assign bus.res_bytes  = bytes;
    assign bus.res_errors = errors;

`ifdef PORT_RESULT_COLLECTOR_MINMAX_EN
    logic [LEN_WIDTH-1:0] len_min, len_max;

    // min starts at all-ones so the first counted frame always replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_min <= '0;
            len_max <= '0;
        end else if (launch) begin
            len_min <= '1;
            len_max <= '0;
        end else if (count) begin
            len_min <= bus.ev_len < len_min ? bus.ev_len : len_min;
            len_max <= bus.ev_len > len_max ? bus.ev_len : len_max;
        end
    end

    assign bus.res_len_min = len_min;
    assign bus.res_len_max = len_max;
`endif
endmodule

// File: tb/tb_port_result_collector.sv
// tb_port_result_collector: directed sessions with a result scoreboard checked whenever res_valid rises.
module tb_port_result_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    port_result_collector_if a ();
    port_result_collector_if #(.FRAME_CNT_WIDTH(3), .BYTE_CNT_WIDTH(10), .ERR_CNT_WIDTH(2), .LEN_WIDTH(8), .DRAIN_WIDTH(4)) b ();

    port_result_collector dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    port_result_collector #(.FRAME_CNT_WIDTH(3), .BYTE_CNT_WIDTH(10), .ERR_CNT_WIDTH(2), .LEN_WIDTH(8), .DRAIN_WIDTH(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    typedef struct {
        longint unsigned frames, good, errors, bytes, mn, mx;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    logic rv_a = 1'b0;
    logic rv_b = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input longint unsigned f, g, e, by, mn, mx);
        exp_t x;
        x.frames = f; x.good = g; x.errors = e; x.bytes = by; x.mn = mn; x.mx = mx;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (a.res_valid && !rv_a) begin
            if (exp_a.size() == 0) begin
                vecs++; errs++;
                $display("FAIL a_unexpected_result: got res_valid with frames %0d, expected no result", a.res_frames);
            end else begin
                e = exp_a.pop_front();
                chk("a_ready", 64'(a.ready), 64'd1);
                chk("a_frames", 64'(a.res_frames), e.frames);
                chk("a_good", 64'(a.res_good), e.good);
                chk("a_errors", 64'(a.res_errors), e.errors);
                chk("a_bytes", 64'(a.res_bytes), e.bytes);
`ifdef PORT_RESULT_COLLECTOR_MINMAX_EN
                chk("a_len_min", 64'(a.res_len_min), e.mn);
                chk("a_len_max", 64'(a.res_len_max), e.mx);
`endif
            end
        end
        if (b.res_valid && !rv_b) begin
            if (exp_b.size() == 0) begin
                vecs++; errs++;
                $display("FAIL b_unexpected_result: got res_valid with frames %0d, expected no result", b.res_frames);
            end else begin
                e = exp_b.pop_front();
                chk("b_frames", 64'(b.res_frames), e.frames);
                chk("b_good", 64'(b.res_good), e.good);
                chk("b_errors", 64'(b.res_errors), e.errors);
                chk("b_bytes", 64'(b.res_bytes), e.bytes);
`ifdef PORT_RESULT_COLLECTOR_MINMAX_EN
                chk("b_len_min", 64'(b.res_len_min), e.mn);
                chk("b_len_max", 64'(b.res_len_max), e.mx);
`endif
            end
        end
        rv_a = a.res_valid;
        rv_b = b.res_valid;
    end

    task automatic cyc_a(input logic s, input logic p, input logic v, input logic [15:0] len, input logic bad);
        a.start = s; a.stop = p; a.ev_valid = v; a.ev_len = len; a.ev_bad = bad;
        @(posedge clk); #1;
        a.start = 0; a.stop = 0; a.ev_valid = 0; a.ev_len = 0; a.ev_bad = 0;
    endtask

    task automatic cyc_b(input logic s, input logic p, input logic v, input logic [7:0] len, input logic bad);
        b.start = s; b.stop = p; b.ev_valid = v; b.ev_len = len; b.ev_bad = bad;
        @(posedge clk); #1;
        b.start = 0; b.stop = 0; b.ev_valid = 0; b.ev_len = 0; b.ev_bad = 0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!(a.ready && a.res_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            vecs++; errs++;
            $display("FAIL %s_timeout: ready/res_valid %b/%b, expected 1/1 within 100 cycles", name, a.ready, a.res_valid);
        end
        cyc_a(0, 0, 0, 0, 0);
    endtask

    task automatic wait_done_b(input string name);
        int n = 0;
        while (!(b.ready && b.res_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            vecs++; errs++;
            $display("FAIL %s_timeout: ready/res_valid %b/%b, expected 1/1 within 100 cycles", name, b.ready, b.res_valid);
        end
        cyc_b(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        a.start = 0; a.stop = 0; a.cfg_drain_cycles = 0; a.ev_valid = 0; a.ev_len = 0; a.ev_bad = 0;
        b.start = 0; b.stop = 0; b.cfg_drain_cycles = 0; b.ev_valid = 0; b.ev_len = 0; b.ev_bad = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", 64'(a.ready), 64'd1);
        chk("rst_res_valid", 64'(a.res_valid), 64'd0);
        chk("rst_frames", 64'(a.res_frames), 64'd0);
        chk("rst_good", 64'(a.res_good), 64'd0);
        chk("rst_bytes", 64'(a.res_bytes), 64'd0);
        chk("rst_errors", 64'(a.res_errors), 64'd0);
        for (int i = 0; i < 3; i++) cyc_a(0, 0, 1, 16'd64, 1'b0);
        chk("idle_drop_frames", 64'(a.res_frames), 64'd0);
        chk("idle_drop_bytes", 64'(a.res_bytes), 64'd0);
        chk("idle_ready", 64'(a.ready), 64'd1);

        // basic session
        exp_a.push_back(mk(13, 11, 2, 3804, 64, 1518));
        cyc_a(1, 0, 0, 0, 0);
        chk("run_ready", 64'(a.ready), 64'd0);
        for (int i = 0; i < 10; i++) cyc_a(0, 0, 1, 16'd64, 1'b0);
        for (int i = 0; i < 2; i++) cyc_a(0, 0, 1, 16'd1518, 1'b1);
        a.cfg_drain_cycles = 16'd4;
        cyc_a(0, 1, 0, 0, 0);
        cyc_a(0, 0, 1, 16'd128, 1'b0);
        wait_done_a("basic");

        // edge cycles: start-cycle event dropped, stop-cycle event counted, post-drain event dropped
        exp_a.push_back(mk(1, 1, 0, 70, 70, 70));
        a.cfg_drain_cycles = 16'd0;
        cyc_a(1, 0, 1, 16'd50, 1'b0);
        chk("edge_res_valid_drop", 64'(a.res_valid), 64'd0);
        chk("edge_cleared", 64'(a.res_frames), 64'd0);
        cyc_a(0, 1, 1, 16'd70, 1'b0);
        chk("edge_drain_ready", 64'(a.ready), 64'd0);
        cyc_a(0, 0, 0, 0, 0);
        chk("edge_done_ready", 64'(a.ready), 64'd1);
        cyc_a(0, 0, 1, 16'd90, 1'b0);
        chk("edge_done_frames", 64'(a.res_frames), 64'd1);

        // restart from DONE; start/stop ignored in DRAIN
        exp_a.push_back(mk(5, 5, 0, 500, 100, 100));
        cyc_a(1, 0, 0, 0, 0);
        chk("restart_res_valid", 64'(a.res_valid), 64'd0);
        chk("restart_cleared", 64'(a.res_bytes), 64'd0);
        for (int i = 0; i < 5; i++) cyc_a(0, 0, 1, 16'd100, 1'b0);
        a.cfg_drain_cycles = 16'd3;
        cyc_a(0, 1, 0, 0, 0);
        cyc_a(1, 0, 0, 0, 0);
        cyc_a(1, 1, 0, 0, 0);
        chk("drain_ignores_start", 64'(a.ready), 64'd0);
        wait_done_a("restart");

        // start+stop together while RUNNING: stop wins and the event is counted
        exp_a.push_back(mk(3, 2, 1, 1624, 60, 1500));
        cyc_a(1, 0, 0, 0, 0);
        cyc_a(0, 0, 1, 16'd60, 1'b0);
        cyc_a(0, 0, 1, 16'd1500, 1'b0);
        a.cfg_drain_cycles = 16'd0;
        cyc_a(1, 1, 1, 16'd64, 1'b1);
        chk("run_stop_wins", 64'(a.ready), 64'd0);
        wait_done_a("minmax");

        // asynchronous reset in the middle of a drain window
        cyc_a(1, 0, 0, 0, 0);
        cyc_a(0, 0, 1, 16'd200, 1'b0);
        a.cfg_drain_cycles = 16'd20;
        cyc_a(0, 1, 1, 16'd300, 1'b1);
        cyc_a(0, 0, 0, 0, 0);
        chk("pre_rst_frames", 64'(a.res_frames), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(a.ready), 64'd1);
        chk("mid_rst_res_valid", 64'(a.res_valid), 64'd0);
        chk("mid_rst_frames", 64'(a.res_frames), 64'd0);
        chk("mid_rst_bytes", 64'(a.res_bytes), 64'd0);
        chk("mid_rst_errors", 64'(a.res_errors), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc_a(0, 0, 0, 0, 0);
        chk("post_rst_res_valid", 64'(a.res_valid), 64'd0);

        // narrow instance: frames/bytes/errors saturate independently, good keeps counting
        exp_b.push_back(mk(7, 5, 3, 1023, 255, 255));
        cyc_b(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc_b(0, 0, 1, 8'd255, 1'b1);
        chk("b_errors_sat_mid", 64'(b.res_errors), 64'd3);
        for (int i = 0; i < 5; i++) cyc_b(0, 0, 1, 8'd255, 1'b0);
        b.cfg_drain_cycles = 4'd0;
        cyc_b(0, 1, 0, 0, 0);
        wait_done_b("sat");

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_empty", 64'(exp_a.size()), 64'd0);
        chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
